wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width in bits; legal values 32 and 64.
REQ-002 Parameter RADDR_W, default 5, register-file address width.
REQ-003 Parameter LINK_REG, default 31, link register index used for JAL/JALR.
REQ-004 Parameter CNT_W, default 32, retire counter width.
REQ-005 Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  instruction present at the stage input.
- stall  in  1  hold all output registers.
- flush  in  1  kill the incoming instruction.
- o  in  DATA_W  ALU result, or link value PC+8.
- d  in  DATA_W  DMEM read word.
- rt  in  RADDR_W  rt field.
- rd  in  RADDR_W  rd field.
- rdst  in  1  destination select: 0 = rt, 1 = rd.
- rwd  in  1  data select: 0 = o, 1 = load result.
- rwe  in  1  register write requested.
- link  in  1  JAL/JALR: force destination to LINK_REG and data to o.
- ld_size  in  2  00 word, 01 half, 10 byte, 11 reserved.
- ld_unsigned  in  1  zero-extend (1) or sign-extend (0).
- addr_lo  in  log2(DATA_W/8)  byte offset of the load address.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  RADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.
- misalign  out  1  registered, one-cycle misaligned-load flag.
- retired  out  CNT_W  count of retired instructions.

Function
REQ-006 Latency shall be exactly one clock: inputs sampled on edge N shall appear on rf_* in the cycle after edge N.
REQ-007 Byte lanes are big-endian: offset 0 selects the most significant byte, so offset k selects d[DATA_W-1-8k -: 8].
REQ-008 ld_size byte shall select one byte; half shall select d[DATA_W-1-8k -: 16]; word shall select DATA_W bits (all of d when DATA_W=32, the 32-bit half selected by addr_lo[2] when DATA_W=64).
REQ-009 Word loads shall be sign- or zero-extended to DATA_W per ld_unsigned when DATA_W=64; byte and half loads shall always be extended per ld_unsigned.
REQ-010 Misalignment is: half with addr_lo[0]=1, or word with a nonzero offset below 4-byte granularity; ld_size=11 shall also count as misaligned.
REQ-011 A misaligned load (rwd=1, accepted) shall force rf_we=0 and set misalign=1 for exactly one cycle.
REQ-012 rf_waddr shall be LINK_REG when link=1, else rd when rdst=1, else rt.
REQ-013 rf_wdata shall be o when link=1 or rwd=0, else the extended load result.
REQ-014 rf_we shall equal valid_in & ~flush & rwe & ~misalign_cond & (waddr != 0); a write to r0 shall be suppressed.
REQ-015 An accepted instruction is one with valid_in=1, stall=0 and flush=0.
REQ-016 retired shall increment by 1 per accepted instruction, including suppressed r0 writes and misaligned loads, and shall wrap from all-ones to 0.
REQ-017 When stall=1, all output registers and retired shall hold their values and misalign shall be cleared; stall takes priority over flush.
REQ-018 When flush=1 and stall=0, the output registers shall load rf_we=0 and misalign=0, and retired shall not increment; rf_waddr and rf_wdata are don't-care.
REQ-019 When valid_in=0 and stall=0, the stage shall load rf_we=0 and misalign=0.

Reset
REQ-020 When rst_n=0, asynchronously: rf_we=0, rf_waddr=0, rf_wdata=0, misalign=0, retired=0.
REQ-021 Reset deassertion shall be synchronised by the instantiating parent; the first accepting edge is the first rising clk edge with rst_n=1.
REQ-022 Reset asserted mid-stall shall override the stall and clear everything per REQ-020.

Verification
REQ-023 Signed byte load: d=0x12F45678, ld_size=10, addr_lo=1, ld_unsigned=0, rwd=1, rdst=0, rt=7 -> next cycle rf_we=1, rf_waddr=7, rf_wdata=0xFFFFFFF4, retired +1.
REQ-024 Unsigned halfword load: d=0x8001ABCD, addr_lo=2, ld_size=01, ld_unsigned=1 -> rf_wdata=0x0000ABCD; the same with addr_lo=1 -> rf_we=0, misalign=1 for one cycle, retired +1.
REQ-025 JAL: link=1, o=0x00400108, rdst=1, rd=3 -> rf_waddr=31, rf_wdata=0x00400108, rf_we=1.
REQ-026 Register 0 and flush: rdst=1, rd=0, rwe=1 -> rf_we=0 and retired +1; flush=1 with a valid instruction -> rf_we=0 and retired unchanged.
REQ-027 Stall, wrap and reset: with retired preset to all-ones, 3 cycles of stall -> outputs frozen; next accepted instruction -> retired=0; rst_n pulsed low mid-cycle -> all outputs 0 immediately, without waiting for clk.
REQ-028 DATA_W=64: d=0x0123456789ABCDEF, ld_size=00, addr_lo=4, ld_unsigned=0 -> rf_wdata=0xFFFFFFFF89ABCDEF.

Source files
------------

// File: rtl/wb_stage_if.sv
// Write-back stage bus: instruction fields from the memory stage in,
// registered register-file write port and retire count out.
interface wb_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
);
  localparam int AW = $clog2(DATA_W / 8);

  logic               valid_in;
  logic               stall;
  logic               flush;
  logic [DATA_W-1:0]  o;
  logic [DATA_W-1:0]  d;
  logic [RADDR_W-1:0] rt;
  logic [RADDR_W-1:0] rd;
  logic               rdst;
  logic               rwd;
  logic               rwe;
  logic               link;
  logic [1:0]         ld_size;
  logic               ld_unsigned;
  logic [AW-1:0]      addr_lo;

  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               misalign;
  logic [CNT_W-1:0]   retired;

  modport master (
    output valid_in, stall, flush, o, d, rt, rd, rdst, rwd, rwe, link,
           ld_size, ld_unsigned, addr_lo,
    input  rf_we, rf_waddr, rf_wdata, misalign, retired
  );

  modport slave (
    input  valid_in, stall, flush, o, d, rt, rd, rdst, rwd, rwe, link,
           ld_size, ld_unsigned, addr_lo,
    output rf_we, rf_waddr, rf_wdata, misalign, retired
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: big-endian load alignment/extension, destination select,
// misaligned-load trap flag and a wrapping retired-instruction counter.
module wb_stage #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);
  localparam logic [RADDR_W-1:0] LINK_A = RADDR_W'(LINK_REG);

  // Extract byte/half/word from the top of a 32-bit window and extend it.
  function automatic logic [DATA_W-1:0] f_extend(
    input logic [31:0] v,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [63:0] t;
    case (sz)
      2'b10:   t = {{56{~uns & v[31]}}, v[31:24]};
      2'b01:   t = {{48{~uns & v[31]}}, v[31:16]};
      default: t = {{32{~uns & v[31]}}, v};
    endcase
    return t[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0]  w_sh;
  logic [DATA_W-1:0]  w_ext;
  logic [DATA_W-1:0]  w_wdata;
  logic [RADDR_W-1:0] w_waddr;
  logic               w_mis_cond;
  logic               w_bad;
  logic               w_live;
  logic               w_accept;
  logic               w_we;
  logic               w_mis;

  // Shifting by the byte offset puts the addressed lane at the MSB end.
  assign w_sh  = bus.d << {bus.addr_lo, 3'b000};
  assign w_ext = f_extend(w_sh[DATA_W-1 -: 32], bus.ld_size, bus.ld_unsigned);

  always_comb begin
    w_mis_cond = 1'b0;
    case (bus.ld_size)
      2'b00:   w_mis_cond = (bus.addr_lo[1:0] != 2'b00);
      2'b01:   w_mis_cond = bus.addr_lo[0];
      2'b10:   w_mis_cond = 1'b0;
      default: w_mis_cond = 1'b1;
    endcase
  end

  assign w_waddr  = bus.link ? LINK_A : (bus.rdst ? bus.rd : bus.rt);
  assign w_wdata  = (bus.link | ~bus.rwd) ? bus.o : w_ext;
  // A link instruction writes o regardless of rwd, so it is never a load.
  assign w_bad    = bus.rwd & ~bus.link & w_mis_cond;
  assign w_live   = bus.valid_in & ~bus.flush;
  assign w_accept = w_live & ~bus.stall;
  assign w_we     = w_live & bus.rwe & ~w_bad & (w_waddr != '0);
  assign w_mis    = w_live & w_bad;

  logic               r_we_p1;
  logic [RADDR_W-1:0] r_waddr_p1;
  logic [DATA_W-1:0]  r_wdata_p1;
  logic               r_mis_p1;
  logic [CNT_W-1:0]   r_retired;

  // ---- p0 -> p1 register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_p1    <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
      r_mis_p1   <= 1'b0;
      r_retired  <= '0;
    end else if (bus.stall) begin
      r_mis_p1   <= 1'b0;
    end else begin
      r_we_p1    <= w_we;
      r_waddr_p1 <= w_waddr;
      r_wdata_p1 <= w_wdata;
      r_mis_p1   <= w_mis;
      if (w_accept) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.rf_we    = r_we_p1;
  assign bus.rf_waddr = r_waddr_p1;
  assign bus.rf_wdata = r_wdata_p1;
  assign bus.misalign = r_mis_p1;
  assign bus.retired  = r_retired;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 32-bit instance with a 4-bit retire counter
// (so wrap is reachable) and a 64-bit instance for doubleword-lane loads.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   exp_ret = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(32), .RADDR_W(5), .CNT_W(4))  ifa ();
  wb_stage_if #(.DATA_W(64), .RADDR_W(5), .CNT_W(32)) ifb ();

  wb_stage #(.DATA_W(32), .RADDR_W(5), .LINK_REG(31), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  wb_stage #(.DATA_W(64), .RADDR_W(5), .LINK_REG(31), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic idle_a();
    ifa.valid_in = 0; ifa.stall = 0; ifa.flush = 0; ifa.o = '0; ifa.d = '0;
    ifa.rt = '0; ifa.rd = '0; ifa.rdst = 0; ifa.rwd = 0; ifa.rwe = 0;
    ifa.link = 0; ifa.ld_size = 2'b00; ifa.ld_unsigned = 0; ifa.addr_lo = '0;
  endtask

  task automatic idle_b();
    ifb.valid_in = 0; ifb.stall = 0; ifb.flush = 0; ifb.o = '0; ifb.d = '0;
    ifb.rt = '0; ifb.rd = '0; ifb.rdst = 0; ifb.rwd = 0; ifb.rwe = 0;
    ifb.link = 0; ifb.ld_size = 2'b00; ifb.ld_unsigned = 0; ifb.addr_lo = '0;
  endtask

  task automatic load_a(input logic [31:0] dv, input logic [1:0] sz,
                        input logic [1:0] off, input logic uns, input logic [4:0] r);
    idle_a();
    ifa.valid_in = 1; ifa.rwe = 1; ifa.rwd = 1; ifa.rt = r;
    ifa.d = dv; ifa.ld_size = sz; ifa.addr_lo = off; ifa.ld_unsigned = uns;
  endtask

  task automatic alu_a(input logic [4:0] r, input logic [31:0] v);
    idle_a();
    ifa.valid_in = 1; ifa.rwe = 1; ifa.rt = r; ifa.o = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ifa.rf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", ifa.rf_we); end
    checks++; if (ifa.rf_waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %0d want 0", ifa.rf_waddr); end
    checks++; if (ifa.rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", ifa.rf_wdata); end
    checks++; if (ifa.misalign !== 1'b0) begin errors++; $display("FAIL rst_mis: got %0b want 0", ifa.misalign); end
    checks++; if (ifa.retired !== 4'd0) begin errors++; $display("FAIL rst_ret: got %0d want 0", ifa.retired); end
    checks++; if (ifb.rf_wdata !== 64'd0) begin errors++; $display("FAIL rst_wdata64: got %h want 0", ifb.rf_wdata); end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte_load();
    load_a(32'h12F45678, 2'b10, 2'd1, 1'b0, 5'd7);
    tick(); exp_ret++;
    checks++; if (ifa.rf_we !== 1'b1) begin errors++; $display("FAIL byte_we: got %0b want 1", ifa.rf_we); end
    checks++; if (ifa.rf_waddr !== 5'd7) begin errors++; $display("FAIL byte_waddr: got %0d want 7", ifa.rf_waddr); end
    checks++; if (ifa.rf_wdata !== 32'hFFFFFFF4) begin errors++; $display("FAIL byte_wdata: got %h want fffffff4", ifa.rf_wdata); end
    checks++; if (ifa.retired !== 4'(exp_ret)) begin errors++; $display("FAIL byte_ret: got %0d want %0d", ifa.retired, exp_ret); end
    load_a(32'h12F45678, 2'b10, 2'd3, 1'b1, 5'd8);
    tick(); exp_ret++;
    checks++; if (ifa.rf_wdata !== 32'h00000078) begin errors++; $display("FAIL byte3_wdata: got %h want 00000078", ifa.rf_wdata); end
  endtask

  task automatic test_half_load();
    load_a(32'h8001ABCD, 2'b01, 2'd2, 1'b1, 5'd4);
    tick(); exp_ret++;
    checks++; if (ifa.rf_wdata !== 32'h0000ABCD) begin errors++; $display("FAIL half_wdata: got %h want 0000abcd", ifa.rf_wdata); end
    checks++; if (ifa.rf_we !== 1'b1) begin errors++; $display("FAIL half_we: got %0b want 1", ifa.rf_we); end
    load_a(32'h8001ABCD, 2'b01, 2'd0, 1'b0, 5'd4);
    tick(); exp_ret++;
    checks++; if (ifa.rf_wdata !== 32'hFFFF8001) begin errors++; $display("FAIL half_sx_wdata: got %h want ffff8001", ifa.rf_wdata); end
    load_a(32'h8001ABCD, 2'b01, 2'd1, 1'b1, 5'd4);
    tick(); exp_ret++;
    checks++; if (ifa.rf_we !== 1'b0) begin errors++; $display("FAIL mis_we: got %0b want 0", ifa.rf_we); end
    checks++; if (ifa.misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %0b want 1", ifa.misalign); end
    checks++; if (ifa.retired !== 4'(exp_ret)) begin errors++; $display("FAIL mis_ret: got %0d want %0d", ifa.retired, exp_ret); end
    idle_a();
    tick();
    checks++; if (ifa.misalign !== 1'b0) begin errors++; $display("FAIL mis_oneshot: got %0b want 0", ifa.misalign); end
    load_a(32'h8001ABCD, 2'b11, 2'd0, 1'b0, 5'd4);
    tick(); exp_ret++;
    checks++; if (ifa.misalign !== 1'b1 || ifa.rf_we !== 1'b0) begin errors++; $display("FAIL mis_rsvd: got mis=%0b we=%0b want mis=1 we=0", ifa.misalign, ifa.rf_we); end
    load_a(32'h8001ABCD, 2'b00, 2'd2, 1'b0, 5'd4);
    tick(); exp_ret++;
    checks++; if (ifa.misalign !== 1'b1) begin errors++; $display("FAIL mis_word: got %0b want 1", ifa.misalign); end
  endtask

  task automatic test_jal();
    idle_a();
    ifa.valid_in = 1; ifa.rwe = 1; ifa.link = 1; ifa.rdst = 1; ifa.rd = 5'd3;
    ifa.o = 32'h00400108; ifa.rwd = 1; ifa.d = 32'hDEADBEEF; ifa.ld_size = 2'b01; ifa.addr_lo = 2'd1;
    tick(); exp_ret++;
    checks++; if (ifa.rf_waddr !== 5'd31) begin errors++; $display("FAIL jal_waddr: got %0d want 31", ifa.rf_waddr); end
    checks++; if (ifa.rf_wdata !== 32'h00400108) begin errors++; $display("FAIL jal_wdata: got %h want 00400108", ifa.rf_wdata); end
    checks++; if (ifa.rf_we !== 1'b1) begin errors++; $display("FAIL jal_we: got %0b want 1", ifa.rf_we); end
  endtask

  task automatic test_r0_flush();
    idle_a();
    ifa.valid_in = 1; ifa.rwe = 1; ifa.rdst = 1; ifa.rd = 5'd0; ifa.rt = 5'd9; ifa.o = 32'h11;
    tick(); exp_ret++;
    checks++; if (ifa.rf_we !== 1'b0) begin errors++; $display("FAIL r0_we: got %0b want 0", ifa.rf_we); end
    checks++; if (ifa.retired !== 4'(exp_ret)) begin errors++; $display("FAIL r0_ret: got %0d want %0d", ifa.retired, exp_ret); end
    load_a(32'h0, 2'b01, 2'd1, 1'b0, 5'd6);
    ifa.flush = 1;
    tick();
    checks++; if (ifa.rf_we !== 1'b0 || ifa.misalign !== 1'b0) begin errors++; $display("FAIL flush_out: got we=%0b mis=%0b want 0 0", ifa.rf_we, ifa.misalign); end
    checks++; if (ifa.retired !== 4'(exp_ret)) begin errors++; $display("FAIL flush_ret: got %0d want %0d", ifa.retired, exp_ret); end
  endtask

  task automatic test_back_to_back();
    alu_a(5'd5, 32'hA5A5_0001);
    tick(); exp_ret++;
    checks++; if (ifa.rf_waddr !== 5'd5 || ifa.rf_wdata !== 32'hA5A50001) begin errors++; $display("FAIL b2b_0: got %0d/%h want 5/a5a50001", ifa.rf_waddr, ifa.rf_wdata); end
    idle_a(); ifa.valid_in = 1; ifa.rwe = 1; ifa.rdst = 1; ifa.rd = 5'd6; ifa.rt = 5'd2; ifa.o = 32'h5A5A_0002;
    tick(); exp_ret++;
    checks++; if (ifa.rf_waddr !== 5'd6 || ifa.rf_wdata !== 32'h5A5A0002) begin errors++; $display("FAIL b2b_1: got %0d/%h want 6/5a5a0002", ifa.rf_waddr, ifa.rf_wdata); end
    idle_a();
    tick();
    checks++; if (ifa.rf_we !== 1'b0) begin errors++; $display("FAIL b2b_idle_we: got %0b want 0", ifa.rf_we); end
    checks++; if (ifa.retired !== 4'(exp_ret)) begin errors++; $display("FAIL b2b_ret: got %0d want %0d", ifa.retired, exp_ret); end
  endtask

  task automatic test_stall_wrap();
    load_a(32'h0, 2'b00, 2'd1, 1'b0, 5'd6);
    tick(); exp_ret++;
    ifa.stall = 1;
    tick();
    checks++; if (ifa.misalign !== 1'b0) begin errors++; $display("FAIL stall_clr_mis: got %0b want 0", ifa.misalign); end
    while (exp_ret < 14) begin
      alu_a(5'd1, 32'(exp_ret));
      tick(); exp_ret++;
    end
    alu_a(5'd9, 32'h55);
    tick(); exp_ret++;
    checks++; if (ifa.retired !== 4'hF) begin errors++; $display("FAIL pre_wrap_ret: got %0d want 15", ifa.retired); end
    alu_a(5'd12, 32'h77);
    ifa.stall = 1;
    for (int i = 0; i < 3; i++) begin
      ifa.flush = (i == 1);
      tick();
      checks++;
      if (ifa.rf_we !== 1'b1 || ifa.rf_waddr !== 5'd9 || ifa.rf_wdata !== 32'h55 || ifa.retired !== 4'hF) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got we=%0b a=%0d d=%h r=%0d want 1/9/55/15", i, ifa.rf_we, ifa.rf_waddr, ifa.rf_wdata, ifa.retired);
      end
    end
    alu_a(5'd12, 32'h77);
    tick();
    checks++; if (ifa.retired !== 4'd0) begin errors++; $display("FAIL wrap_ret: got %0d want 0", ifa.retired); end
    checks++; if (ifa.rf_waddr !== 5'd12 || ifa.rf_wdata !== 32'h77) begin errors++; $display("FAIL wrap_data: got %0d/%h want 12/77", ifa.rf_waddr, ifa.rf_wdata); end
  endtask

  task automatic test_async_reset();
    alu_a(5'd3, 32'hCAFE);
    tick();
    ifa.stall = 1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.rf_we !== 1'b0 || ifa.rf_waddr !== 5'd0 || ifa.rf_wdata !== 32'd0 || ifa.misalign !== 1'b0 || ifa.retired !== 4'd0) begin
      errors++;
      $display("FAIL async_rst: got we=%0b a=%0d d=%h m=%0b r=%0d want all 0", ifa.rf_we, ifa.rf_waddr, ifa.rf_wdata, ifa.misalign, ifa.retired);
    end
    idle_a();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_w64();
    idle_b();
    ifb.valid_in = 1; ifb.rwe = 1; ifb.rwd = 1; ifb.rt = 5'd2;
    ifb.d = 64'h0123456789ABCDEF; ifb.ld_size = 2'b00; ifb.addr_lo = 3'd4; ifb.ld_unsigned = 0;
    tick();
    checks++; if (ifb.rf_wdata !== 64'hFFFFFFFF89ABCDEF) begin errors++; $display("FAIL w64_hi_off4: got %h want ffffffff89abcdef", ifb.rf_wdata); end
    checks++; if (ifb.rf_we !== 1'b1) begin errors++; $display("FAIL w64_we: got %0b want 1", ifb.rf_we); end
    ifb.addr_lo = 3'd0; ifb.ld_unsigned = 1;
    tick();
    checks++; if (ifb.rf_wdata !== 64'h0000000001234567) begin errors++; $display("FAIL w64_off0: got %h want 0000000001234567", ifb.rf_wdata); end
    ifb.ld_size = 2'b10; ifb.addr_lo = 3'd7; ifb.ld_unsigned = 0;
    tick();
    checks++; if (ifb.rf_wdata !== 64'hFFFFFFFFFFFFFFEF) begin errors++; $display("FAIL w64_byte7: got %h want ffffffffffffffef", ifb.rf_wdata); end
    ifb.ld_size = 2'b00; ifb.addr_lo = 3'd2;
    tick();
    checks++; if (ifb.misalign !== 1'b1 || ifb.rf_we !== 1'b0) begin errors++; $display("FAIL w64_mis: got mis=%0b we=%0b want 1 0", ifb.misalign, ifb.rf_we); end
    idle_b();
  endtask

  initial begin
    idle_a();
    idle_b();
    test_reset();
    test_byte_load();
    test_half_load();
    test_jal();
    test_r0_flush();
    test_back_to_back();
    test_stall_wrap();
    test_async_reset();
    test_w64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
